// File: rtl/rd_empty_sync.sv
// Read-domain empty-flag generator: synchronizes the Gray write pointer, derives empty and
// the Gray read pointer; optional occupancy/almost-empty outputs under `RD_LEVEL_EN`.
module rd_empty_sync #(
    parameter int DEPTH         = 16,
    parameter int ADDR_WIDTH    = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
    input  logic [ADDR_WIDTH:0]   rd_ptr_ext,
    input  logic                  rd_inc,
    output logic                  empty,
`ifdef RD_LEVEL_EN
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  almost_empty,
`endif
    output logic [ADDR_WIDTH:0]   rd_ptr_gray
);

    if (DEPTH != (1 << ADDR_WIDTH) || SYNC_STAGES < 2 || SYNC_STAGES > 3 ||
        AEMPTY_THRESH < 1 || AEMPTY_THRESH > DEPTH - 1) begin : g_param_check
        $error("rd_empty_sync: illegal parameter combination");
    end

    // Plain flop chain: no logic between stages so each bit resolves independently.
    logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
    logic [ADDR_WIDTH:0] wr_gray_sync;

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_ptr_gray;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wr_gray_sync = sync_q[SYNC_STAGES-1];

    logic [ADDR_WIDTH:0] rd_ptr_next;
    logic [ADDR_WIDTH:0] rd_gray_d;
    logic                empty_d;
    logic [ADDR_WIDTH:0] rd_gray_q;
    logic                empty_q;

    always_comb begin
        rd_ptr_next = rd_ptr_ext + {{ADDR_WIDTH{1'b0}}, rd_inc};
        rd_gray_d   = (rd_ptr_next >> 1) ^ rd_ptr_next;
        empty_d     = (rd_gray_d == wr_gray_sync);
    end

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            rd_gray_q <= '0;
            empty_q   <= 1'b1;
        end else begin
            rd_gray_q <= rd_gray_d;
            empty_q   <= empty_d;
        end
    end

    assign empty       = empty_q;
    assign rd_ptr_gray = rd_gray_q;

`ifdef RD_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] AE_THR = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [ADDR_WIDTH:0] wr_bin_sync;
    logic [ADDR_WIDTH:0] level_d;
    logic                aempty_d;
    logic [ADDR_WIDTH:0] level_q;
    logic                aempty_q;

    // Gray to binary: each bit is the XOR of all Gray bits at and above it.
    always_comb begin
        wr_bin_sync             = '0;
        wr_bin_sync[ADDR_WIDTH] = wr_gray_sync[ADDR_WIDTH];
        for (int unsigned j = 1; j <= ADDR_WIDTH; j++) begin
            wr_bin_sync[ADDR_WIDTH-j] = wr_bin_sync[ADDR_WIDTH-j+1] ^ wr_gray_sync[ADDR_WIDTH-j];
        end
        level_d  = wr_bin_sync - rd_ptr_next;
        aempty_d = (level_d <= AE_THR);
    end

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            level_q  <= '0;
            aempty_q <= 1'b1;
        end else begin
            level_q  <= level_d;
            aempty_q <= aempty_d;
        end
    end

    assign rd_level     = level_q;
    assign almost_empty = aempty_q;
`endif

endmodule

// File: tb/tb_rd_empty_sync.sv
// Directed bench for rd_empty_sync: table of per-cycle vectors plus hand sequences for
// full-depth drain, pointer wrap and mid-operation reset.
module tb_rd_empty_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] wr_ptr_gray;
    logic [4:0] rd_ptr_ext;
    logic       rd_inc;
    logic       empty;
    logic [4:0] rd_ptr_gray;
`ifdef RD_LEVEL_EN
    logic [4:0] rd_level;
    logic       almost_empty;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rd_empty_sync #(
        .DEPTH(16),
        .ADDR_WIDTH(4),
        .SYNC_STAGES(2),
        .AEMPTY_THRESH(2)
    ) dut (
        .rd_clk(clk),
        .rst_n(rst_n),
        .wr_ptr_gray(wr_ptr_gray),
        .rd_ptr_ext(rd_ptr_ext),
        .rd_inc(rd_inc),
        .empty(empty),
`ifdef RD_LEVEL_EN
        .rd_level(rd_level),
        .almost_empty(almost_empty),
`endif
        .rd_ptr_gray(rd_ptr_gray)
    );

    typedef struct {
        logic       rst_n;
        logic [4:0] wg;
        logic [4:0] rp;
        logic       inc;
        logic       e_empty;
        logic [4:0] e_rg;
        logic [4:0] e_lvl;
        logic       e_ae;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [4:0] gray(input int unsigned n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [4:0] wg, input logic [4:0] rp, input logic inc);
        rst_n       = r;
        wr_ptr_gray = wg;
        rd_ptr_ext  = rp;
        rd_inc      = inc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic e, input logic [4:0] rg,
                           input logic [4:0] lvl, input logic ae);
        chk({nm, ".empty"}, 32'(empty), 32'(e));
        chk({nm, ".rd_ptr_gray"}, 32'(rd_ptr_gray), 32'(rg));
`ifdef RD_LEVEL_EN
        chk({nm, ".rd_level"}, 32'(rd_level), 32'(lvl));
        chk({nm, ".almost_empty"}, 32'(almost_empty), 32'(ae));
`else
        if (lvl === 5'bx && ae === 1'bx) chk({nm, ".unreachable"}, 32'(empty), 32'(e));
`endif
    endtask

    initial begin
        // rst, wg, rp, inc | empty, rg, lvl, ae
        vecs[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1};
        vecs[1]  = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1};
        vecs[2]  = '{1'b1, 5'd2, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1};
        vecs[3]  = '{1'b1, 5'd2, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1};
        vecs[4]  = '{1'b1, 5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 5'd3, 1'b0};
        vecs[5]  = '{1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd1, 5'd2, 1'b1};
        vecs[6]  = '{1'b1, 5'd2, 5'd1, 1'b1, 1'b0, 5'd3, 5'd1, 1'b1};
        vecs[7]  = '{1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 5'd0, 1'b1};
        vecs[8]  = '{1'b1, 5'd2, 5'd3, 1'b0, 1'b1, 5'd2, 5'd0, 1'b1};
        vecs[9]  = '{1'b1, 5'd7, 5'd3, 1'b0, 1'b1, 5'd2, 5'd0, 1'b1};
        vecs[10] = '{1'b1, 5'd7, 5'd3, 1'b0, 1'b1, 5'd2, 5'd0, 1'b1};
        vecs[11] = '{1'b1, 5'd7, 5'd3, 1'b0, 1'b0, 5'd2, 5'd2, 1'b1};
        vecs[12] = '{1'b1, 5'd5, 5'd3, 1'b0, 1'b0, 5'd2, 5'd2, 1'b1};
        vecs[13] = '{1'b1, 5'd5, 5'd3, 1'b0, 1'b0, 5'd2, 5'd2, 1'b1};
        vecs[14] = '{1'b1, 5'd5, 5'd3, 1'b1, 1'b0, 5'd6, 5'd2, 1'b1};
        vecs[15] = '{1'b1, 5'd5, 5'd4, 1'b0, 1'b0, 5'd6, 5'd2, 1'b1};

        rst_n = 1'b0; wr_ptr_gray = '0; rd_ptr_ext = '0; rd_inc = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst_n, vecs[i].wg, vecs[i].rp, vecs[i].inc);
            chk_all($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_rg, vecs[i].e_lvl, vecs[i].e_ae);
        end

        // Full FIFO (lap bit set) drained completely.
        step(1'b0, 5'd24, 5'd0, 1'b0);
        step(1'b1, 5'd24, 5'd0, 1'b0);
        step(1'b1, 5'd24, 5'd0, 1'b0);
        step(1'b1, 5'd24, 5'd0, 1'b0);
        chk_all("full", 1'b0, 5'd0, 5'd16, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 5'd24, 5'(i), 1'b1);
            chk_all($sformatf("drain%0d", i), (i == 15), gray(i + 1), 5'(15 - i), (15 - i) <= 2);
        end

        // Pointer wrap 31 -> 0 against synchronized write pointer 0.
        step(1'b0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd0, 5'd30, 1'b0);
        chk_all("wrap30", 1'b0, 5'd17, 5'd2, 1'b1);
        step(1'b1, 5'd0, 5'd31, 1'b0);
        chk_all("wrap31", 1'b0, 5'd16, 5'd1, 1'b1);
        step(1'b1, 5'd0, 5'd31, 1'b1);
        chk_all("wrap0", 1'b1, 5'd0, 5'd0, 1'b1);
        step(1'b1, 5'd0, 5'd0, 1'b1);
        chk("underflow.rd_ptr_gray", 32'(rd_ptr_gray), 32'd1);

        // Level 5, then reset coinciding with a read.
        step(1'b1, 5'd7, 5'd0, 1'b0);
        step(1'b1, 5'd7, 5'd0, 1'b0);
        step(1'b1, 5'd7, 5'd0, 1'b0);
        chk_all("lvl5", 1'b0, 5'd0, 5'd5, 1'b0);
        step(1'b0, 5'd7, 5'd0, 1'b1);
        chk_all("rst_mid", 1'b1, 5'd0, 5'd0, 1'b1);
        step(1'b1, 5'd7, 5'd0, 1'b0);
        chk_all("post_rst1", 1'b1, 5'd0, 5'd0, 1'b1);
        step(1'b1, 5'd7, 5'd0, 1'b0);
        chk_all("post_rst2", 1'b1, 5'd0, 5'd0, 1'b1);
        step(1'b1, 5'd7, 5'd0, 1'b0);
        chk_all("post_rst3", 1'b0, 5'd0, 5'd5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
